// File: rtl/sample_mix_pkg.sv
// sample_mix_pkg: shared sizes, FSM encoding and helpers for the voice sample mixer.
package sample_mix_pkg;
    localparam int NUM_VOICES = 4;
    localparam int SAMPLE_W   = 8;
    localparam int ACC_W      = 10;
    localparam int PERIOD_LEN = 256;
    localparam int CNT_W      = $clog2(PERIOD_LEN);
    localparam int PTR_W      = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_VOICES-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            if (oh[i]) idx = PTR_W'(i);
        return idx;
    endfunction
endpackage

// File: rtl/sample_mix_ctrl_rr_arb4.sv
// rr_arb4: combinational round-robin arbiter; grants the first request found
// searching upward from ptr with wrap-around.
module rr_arb4
    import sample_mix_pkg::*;
(
    input  logic [NUM_VOICES-1:0] req,
    input  logic [PTR_W-1:0]      ptr,
    output logic [NUM_VOICES-1:0] gnt
);
    // Descending scan: the smallest offset from ptr is written last and wins.
    always_comb begin
        gnt = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--)
            if (req[ptr + PTR_W'(i)]) gnt = NUM_VOICES'(1) << (ptr + PTR_W'(i));
    end
endmodule

// File: rtl/sample_mix_ctrl.sv
// sample_mix_ctrl: collects one sample per voice each 256-cycle period and publishes the mix to the PWM stage.
// MIX_SATURATE_EN selects a saturating sum as the mix; otherwise the sum is averaged over 4 slots.
module sample_mix_ctrl
    import sample_mix_pkg::*;
(
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               enable,
    input  logic [NUM_VOICES-1:0]              voice_valid,
    input  logic [NUM_VOICES-1:0][SAMPLE_W-1:0] voice_sample,
    output logic [NUM_VOICES-1:0]              voice_ready,
    output logic [SAMPLE_W-1:0]                mixed_sample,
    output logic                               period_start,
    output logic                               underrun
);
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      p_q, p_d, last_q, last_d, gidx;
    logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
    logic [NUM_VOICES-1:0] served_q, served_d, req, grant, taken;
    logic [SAMPLE_W-1:0]   mixed_sample_q, mixed_sample_d, mix_val;
    logic                  period_start_q, period_start_d, underrun_q, underrun_d, tick, xfer;

    assign req = voice_valid & ~served_q;

    rr_arb4 u_arb (.req(req), .ptr(p_q), .gnt(grant));

    assign voice_ready = (state_q == COLLECT) ? grant : '0;
    assign xfer        = |voice_ready;
    assign gidx        = onehot_idx(voice_ready);
    assign acc_sum     = acc_q + (xfer ? ACC_W'(voice_sample[gidx]) : '0);
    assign taken       = served_q | voice_ready;
    assign tick        = enable && cnt_q == CNT_W'(PERIOD_LEN - 1);

`ifdef MIX_SATURATE_EN
    assign mix_val = (acc_sum > ACC_W'((1 << SAMPLE_W) - 1)) ? '1 : SAMPLE_W'(acc_sum);
`else
    assign mix_val = SAMPLE_W'(acc_sum >> 2);
`endif

    // A grant on the tick cycle is folded into that tick's mix via acc_sum/taken.
    always_comb begin
        state_d        = state_q;
        cnt_d          = enable ? cnt_q + CNT_W'(1) : '0;
        p_d            = p_q;
        last_d         = xfer ? gidx : last_q;
        acc_d          = acc_sum;
        served_d       = taken;
        mixed_sample_d = mixed_sample_q;
        period_start_d = 1'b0;
        underrun_d     = 1'b0;
        if (!enable) begin
            state_d        = IDLE;
            acc_d          = '0;
            served_d       = '0;
            mixed_sample_d = '0;
        end else if (state_q == IDLE) begin
            state_d = COLLECT;
        end else if (tick) begin
            state_d        = COLLECT;
            mixed_sample_d = mix_val;
            acc_d          = '0;
            served_d       = '0;
            period_start_d = 1'b1;
            underrun_d     = ~|taken;
            p_d            = |taken ? last_d + PTR_W'(1) : p_q;
        end else if (state_q == COLLECT && !xfer) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            p_q            <= '0;
            last_q         <= '0;
            acc_q          <= '0;
            served_q       <= '0;
            mixed_sample_q <= '0;
            period_start_q <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            p_q            <= p_d;
            last_q         <= last_d;
            acc_q          <= acc_d;
            served_q       <= served_d;
            mixed_sample_q <= mixed_sample_d;
            period_start_q <= period_start_d;
            underrun_q     <= underrun_d;
        end
    end

    assign mixed_sample = mixed_sample_q;
    assign period_start = period_start_q;
    assign underrun     = underrun_q;
endmodule

// File: doc/sample_mix_ctrl.md
SAMPLE_MIX_CTRL -- requirements
Module: sample_mix_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have ports: nrst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: enable  in  1  playback enable, shared with the PWM output stage.
REQ-004 SHALL have ports: voice_valid  in  4  per-voice sample-offered flags.
REQ-005 SHALL have ports: voice_sample  in  4x8  per-voice unsigned 8-bit samples.
REQ-006 SHALL have ports: voice_ready  out  4  per-voice accept strobe, at most one bit high.
REQ-007 SHALL have ports: mixed_sample  out  8  registered mixed sample feeding the PWM duty input.
REQ-008 SHALL have ports: period_start  out  1  one-cycle pulse, registered, on the cycle mixed_sample updates.
REQ-009 SHALL have ports: underrun  out  1  one-cycle pulse when a period closes with zero samples accepted.

Function
REQ-010 SHALL keep an 8-bit period counter: +1 per cycle while enable=1, wraps 255->0, forced to 0 while enable=0.
REQ-011 SHALL define tick = enable AND counter==255; a period equals 256 cycles.
REQ-012 SHALL implement FSM states IDLE, COLLECT, HOLD.
REQ-013 IDLE: enable=0 -> stay; voice_ready=0; enable=1 -> COLLECT on the next cycle.
REQ-014 COLLECT: each cycle, grant the first voice with valid=1 and not served this period, searching from pointer p upward mod 4; voice_ready is combinational from state/valid/served.
REQ-015 Transfer SHALL occur on valid AND ready; the sample is added to a 10-bit accumulator and the voice is marked served.
REQ-016 COLLECT -> HOLD when no unserved voice has valid=1 (this includes all four served); valid raised later waits for the next period.
REQ-017 HOLD: voice_ready=0; wait for tick.
REQ-018 On tick in COLLECT or HOLD: mixed_sample <= mix(accumulator, including any same-cycle transfer); clear accumulator and served flags; p <= (last granted voice + 1) mod 4 (unchanged if none); next state COLLECT.
REQ-019 Latency: a sample accepted in period N appears on mixed_sample the cycle after the tick that closes period N; period_start pulses on that same cycle.
REQ-020 underrun SHALL pulse alongside period_start when the closing period accepted zero samples; mixed_sample then becomes 0.
REQ-021 enable falling in any state: next cycle state=IDLE, mixed_sample=0, accumulator/served cleared, p kept, no pulses.
REQ-022 Without the macro, mix = accumulator >> 2 (average over 4 voice slots; unaccepted voices count as 0).

Reset
REQ-023 nrst=1 SHALL immediately force state=IDLE, counter=0, p=0, accumulator=0, served=0, mixed_sample=0, period_start=0, underrun=0; voice_ready=0 follows combinationally.
REQ-024 Reset mid-COLLECT SHALL discard the partial accumulation; the first period after release starts from the IDLE->COLLECT sequence.

Configuration
REQ-025 Macro MIX_SATURATE_EN defined: mix = min(accumulator, 255); no division.
REQ-026 Macro absent: mix per REQ-022; all other behaviour identical.

Structure
REQ-027 Package sample_mix_pkg SHALL hold NUM_VOICES=4, SAMPLE_W=8, ACC_W=10, PERIOD_LEN=256, and the FSM state enum.
REQ-028 Round-robin grant logic SHALL be a sub-module rr_arb4 (request, pointer in; one-hot grant out; combinational).

Verification
REQ-029 Voices 0..3 valid with 10,20,30,40, enable=1 -> accepted on cycles 1..4 in order 0,1,2,3; after the first tick mixed_sample=25 (100 with MIX_SATURATE_EN), period_start=1.
REQ-030 Samples 200,100,0,0 -> mixed_sample=75 without the macro; 255 with MIX_SATURATE_EN.
REQ-031 Only voice 2 valid (value 80) from mid-period, state HOLD -> not accepted until the next COLLECT; then mixed_sample=20 one period later.
REQ-032 No voice valid for a full period -> underrun=1 and period_start=1 on the same cycle, mixed_sample=0.
REQ-033 Transfer on the tick cycle -> sample included in that tick's mix; enable dropped mid-COLLECT -> next cycle voice_ready=0, mixed_sample=0, state IDLE.
REQ-034 nrst pulsed mid-COLLECT with accumulator=60 -> all outputs 0 immediately; after release, the first mix excludes the 60.
